// File: rtl/alu_pkg.sv
// Shared types and op-decode helpers for the alu_mdu execute unit.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLL    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_SLTU   = 5'h08,
    OP_SLT    = 5'h09,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ALU,
    MUL,
    DIV,
    DONE
  } state_e;

  function automatic logic is_legal(logic [4:0] op);
    return op[4] ? (op[3] == 1'b0) : (op <= 5'h09);
  endfunction

  function automatic logic is_mext(logic [4:0] op);
    return is_legal(op) && op[4];
  endfunction

  function automatic logic is_div(logic [4:0] op);
    return is_legal(op) && op[4] && op[2];
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response handshake bundle between operand select and writeback.
interface alu_mdu_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OP_CODE_WIDTH = 5,
  parameter int TAG_WIDTH     = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [OP_CODE_WIDTH-1:0] in_op;
  logic [DATA_WIDTH-1:0]    in_a;
  logic [DATA_WIDTH-1:0]    in_b;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_result;
  logic [TAG_WIDTH-1:0]     out_tag;
  logic                     out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal
  );
endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring unsigned divider: one quotient bit per cycle after start.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH:0]   partial, diff;

  // Shift the next dividend bit into the partial remainder, keep the difference if non-negative.
  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (start && !busy_q) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CW'(WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/alu_mdu.sv
// Integer execute unit: base ALU ops plus RV32M multiply/divide, one op in flight.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OP_CODE_WIDTH = 5,
  parameter int TAG_WIDTH     = 5,
  parameter int MUL_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  alu_mdu_if.slave   bus
);
  localparam int W     = DATA_WIDTH;
  localparam int SH_W  = $clog2(W);
  localparam int CNT_W = $clog2(MUL_STAGES + 1) + 1;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  state_e                   state_q, state_d;
  logic [OP_CODE_WIDTH-1:0] op_q, op_d;
  logic [W-1:0]             a_q, a_d, b_q, b_d, result_q, result_d;
  logic [TAG_WIDTH-1:0]     tag_q, tag_d;
  logic                     illegal_q, illegal_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [4:0]   op5;
  logic [W-1:0] alu_res, mul_res, div_res;

  function automatic logic op_legal(logic [OP_CODE_WIDTH-1:0] op);
    return ((op >> 5) == '0) && is_legal(op[4:0]);
  endfunction

  // Divide-by-zero and signed overflow have fixed answers and skip the iterative path.
  function automatic logic div_special(logic sgn, logic [W-1:0] a, logic [W-1:0] b);
    return (b == '0) || (sgn && (a == MIN_VAL) && (b == '1));
  endfunction

  assign op5 = op_q[4:0];

  always_comb begin
    alu_res = '0;
    case (op_e'(op5))
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << b_q[SH_W-1:0];
      OP_SRL:  alu_res = a_q >> b_q[SH_W-1:0];
      OP_SRA:  alu_res = $unsigned($signed(a_q) >>> b_q[SH_W-1:0]);
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (a_q < b_q)};
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_DIV, OP_DIVU: alu_res = (b_q == '0) ? '1 : MIN_VAL;
      OP_REM, OP_REMU: alu_res = (b_q == '0) ? a_q : '0;
      default: alu_res = '0;
    endcase
  end

  // Operands are sign- or zero-extended per op, then multiplied as 2W-bit values.
  logic           a_msext, b_msext;
  logic [2*W-1:0] mul_a, mul_b, mul_prod, prod_last;

  assign a_msext  = (op5[1:0] != 2'b11) && a_q[W-1];
  assign b_msext  = !op5[1] && b_q[W-1];
  assign mul_a    = {{W{a_msext}}, a_q};
  assign mul_b    = {{W{b_msext}}, b_q};
  assign mul_prod = mul_a * mul_b;

  generate
    if (MUL_STAGES > 1) begin : g_mul_pipe
      logic [2*W-1:0] pipe_q [MUL_STAGES-1];
      logic [2*W-1:0] pipe_d [MUL_STAGES-1];
      always_comb begin
        pipe_d[0] = mul_prod;
        for (int i = 1; i < MUL_STAGES - 1; i++) pipe_d[i] = pipe_q[i-1];
      end
      always_ff @(posedge clk) begin
        for (int i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_d[i];
      end
      assign prod_last = pipe_q[MUL_STAGES-2];
    end else begin : g_mul_comb
      assign prod_last = mul_prod;
    end
  endgenerate

  assign mul_res = (op5[1:0] == 2'b00) ? prod_last[W-1:0] : prod_last[2*W-1:W];

  logic         a_neg, b_neg, div_start, div_busy, div_done;
  logic [W-1:0] div_dividend, div_divisor, div_quo, div_rem, quo_fix, rem_fix;

  assign a_neg        = !op5[0] && a_q[W-1];
  assign b_neg        = !op5[0] && b_q[W-1];
  assign div_dividend = a_neg ? -a_q : a_q;
  assign div_divisor  = b_neg ? -b_q : b_q;
  assign div_start    = (state_q == DIV) && (cnt_q == '0) && !div_busy;
  assign quo_fix      = (a_neg ^ b_neg) ? -div_quo : div_quo;
  assign rem_fix      = a_neg ? -div_rem : div_rem;
  assign div_res      = op5[1] ? rem_fix : quo_fix;

  div_iter #(.WIDTH(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    tag_d     = tag_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d  = bus.in_op;
          a_d   = bus.in_a;
          b_d   = bus.in_b;
          tag_d = bus.in_tag;
          cnt_d = '0;
          if (!op_legal(bus.in_op) || !is_mext(bus.in_op[4:0]))
            state_d = ALU;
          else if (!is_div(bus.in_op[4:0]))
            state_d = MUL;
          else if (div_special(!bus.in_op[0], bus.in_a, bus.in_b))
            state_d = ALU;
          else
            state_d = DIV;
        end
      end
      ALU: begin
        result_d  = alu_res;
        illegal_d = !op_legal(op_q);
        state_d   = DONE;
      end
      MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(MUL_STAGES - 1)) begin
          result_d  = mul_res;
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DIV: begin
        if (cnt_q == '0) cnt_d = CNT_W'(1);
        if (div_done) begin
          result_d  = div_res;
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_result  = result_q;
  assign bus.out_tag     = tag_q;
  assign bus.out_illegal = illegal_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu with hand-computed expected results.
module tb_alu_mdu;
  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  alu_mdu_if bus ();

  alu_mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Present one op, wait for its accept edge, then count edges until out_valid.
  task automatic issue_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output int lat, output logic ready_seen);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat          = 0;
    ready_seen   = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ready_seen = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic take_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset in_ready: got %b expected 1", bus.in_ready);
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset out_valid: got %b expected 0", bus.out_valid);
    end
    tests_run++;
    if (bus.out_result !== 32'h0 || bus.out_tag !== 5'h0 || bus.out_illegal !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset outputs: got result %h tag %h illegal %b expected 0/0/0",
               bus.out_result, bus.out_tag, bus.out_illegal);
    end
  endtask

  task automatic test_alu();
    logic [4:0]  ops [6] = '{5'h00, 5'h07, 5'h01, 5'h09, 5'h08, 5'h05};
    logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
    logic [31:0] bs  [6] = '{32'h1, 32'h24, 32'h7, 32'h1, 32'h1, 32'h3F};
    logic [31:0] exp [6] = '{32'h0, 32'hF800_0000, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h8000_0000};
    int   lat;
    logic rs;
    for (int i = 0; i < 6; i++) begin
      issue_op(ops[i], as[i], bs[i], 5'(i + 3), lat, rs);
      tests_run++;
      if (bus.out_result !== exp[i] || bus.out_tag !== 5'(i + 3) || lat != 1) begin
        tests_failed++;
        $display("[TB] FAIL alu[%0d]: got result %h tag %0d latency %0d expected %h tag %0d latency 1",
                 i, bus.out_result, bus.out_tag, lat, exp[i], i + 3);
      end
      take_result();
    end
  endtask

  task automatic test_mul();
    logic [4:0]  ops [4] = '{5'h11, 5'h13, 5'h10, 5'h12};
    logic [31:0] as  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF};
    int   lat;
    logic rs;
    for (int i = 0; i < 4; i++) begin
      issue_op(ops[i], as[i], bs[i], 5'(i + 10), lat, rs);
      tests_run++;
      if (bus.out_result !== exp[i] || bus.out_tag !== 5'(i + 10) || lat != 2 || rs !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL mul[%0d]: got result %h tag %0d latency %0d ready %b expected %h tag %0d latency 2 ready 0",
                 i, bus.out_result, bus.out_tag, lat, rs, exp[i], i + 10);
      end
      take_result();
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [5] = '{5'h14, 5'h16, 5'h15, 5'h17, 5'h16};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE};
    logic [31:0] exp [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'd1};
    int   lat;
    logic rs;
    for (int i = 0; i < 5; i++) begin
      issue_op(ops[i], as[i], bs[i], 5'(i + 20), lat, rs);
      tests_run++;
      if (bus.out_result !== exp[i] || bus.out_tag !== 5'(i + 20) || lat != 34 || rs !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL div[%0d]: got result %h tag %0d latency %0d ready %b expected %h tag %0d latency 34 ready 0",
                 i, bus.out_result, bus.out_tag, lat, rs, exp[i], i + 20);
      end
      take_result();
    end
  endtask

  task automatic test_div_special();
    logic [4:0]  ops [4] = '{5'h15, 5'h16, 5'h14, 5'h16};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int   lat;
    logic rs;
    for (int i = 0; i < 4; i++) begin
      issue_op(ops[i], as[i], bs[i], 5'(i + 1), lat, rs);
      tests_run++;
      if (bus.out_result !== exp[i] || bus.out_illegal !== 1'b0 || lat != 1) begin
        tests_failed++;
        $display("[TB] FAIL div_special[%0d]: got result %h illegal %b latency %0d expected %h illegal 0 latency 1",
                 i, bus.out_result, bus.out_illegal, lat, exp[i]);
      end
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic rs;
    logic stable;
    issue_op(5'h00, 32'd10, 32'd20, 5'd7, lat, rs);
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_result !== 32'd30 || bus.out_tag !== 5'd7 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        stable = 1'b0;
    end
    tests_run++;
    if (stable !== 1'b1 || bus.out_result !== 32'd30) begin
      tests_failed++;
      $display("[TB] FAIL backpressure hold: got stable %b result %h expected stable 1 result 0000001e",
               stable, bus.out_result);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = 5'h04;
    bus.in_a      = 32'h0000_F0F0;
    bus.in_b      = 32'h0000_0FF0;
    bus.in_tag    = 5'd9;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL release: got in_ready %b out_valid %b expected 1 0", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL new accept: got in_ready %b expected 0", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h0000_FF00 || bus.out_tag !== 5'd9) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back result: got valid %b result %h tag %0d expected 1 0000ff00 9",
               bus.out_valid, bus.out_result, bus.out_tag);
    end
    take_result();
  endtask

  task automatic test_reset_mid_div();
    int   lat;
    logic rs;
    logic stale;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 5'h14;
    bus.in_a     = 32'd100;
    bus.in_b     = 32'd3;
    bus.in_tag   = 5'd5;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== 32'h0 || bus.out_tag !== 5'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_div reset: got ready %b valid %b result %h tag %0d expected 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag);
    end
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale = 1'b1;
    end
    tests_run++;
    if (stale !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stale result: got out_valid seen %b expected 0", stale);
    end
    issue_op(5'h00, 32'd2, 32'd2, 5'd1, lat, rs);
    tests_run++;
    if (bus.out_result !== 32'd4 || bus.out_tag !== 5'd1 || lat != 1) begin
      tests_failed++;
      $display("[TB] FAIL add after reset: got result %h tag %0d latency %0d expected 4 tag 1 latency 1",
               bus.out_result, bus.out_tag, lat);
    end
    take_result();
    issue_op(5'h0A, 32'd5, 32'd6, 5'd2, lat, rs);
    tests_run++;
    if (bus.out_illegal !== 1'b1 || bus.out_result !== 32'h0 || bus.out_tag !== 5'd2 || lat != 1) begin
      tests_failed++;
      $display("[TB] FAIL illegal op: got illegal %b result %h tag %0d latency %0d expected 1 0 2 latency 1",
               bus.out_illegal, bus.out_result, bus.out_tag, lat);
    end
    take_result();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    test_reset();
    test_alu();
    test_mul();
    test_div();
    test_div_special();
    test_back_to_back();
    test_reset_mid_div();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
